// File: rtl/imem_fetch_port.sv
// Instruction memory with a registered fetch port (valid/ready), flush, fault reporting
// and a runtime load port with write-first forwarding into the fetch path.
module imem_fetch_port #(
    parameter int unsigned DATA_W                = 32,
    parameter int unsigned ADDR_W                = 32,
    parameter int unsigned DEPTH                 = 32,
    parameter logic [DATA_W-1:0] FILL_WORD       = 32'h003F0000
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    input  logic              flush,
    output logic              wr_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

    // Power-up contents only; reset deliberately leaves the array alone.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: FILL_WORD};

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;
    logic              wr_err_q, wr_err_d;

    logic              wr_in_range, req_in_range, wr_en, accept, collide;
    logic [IdxW-1:0]   wr_idx, req_idx;

    always_comb begin
        wr_in_range  = addra < DepthA;
        req_in_range = req_addr < DepthA;
        wr_idx       = addra[IdxW-1:0];
        req_idx      = req_addr[IdxW-1:0];
        wr_en        = rst_n && wea && wr_in_range;
        req_ready    = rst_n && (!resp_valid_q || resp_ready) && !flush;
        accept       = req_valid && req_ready;
        collide      = wr_en && (addra == req_addr);
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        wr_err_d     = wea && !wr_in_range;
        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_fault_d = !req_in_range;
            if (!req_in_range) begin
                resp_data_d = FILL_WORD;
            end else if (collide) begin
                resp_data_d = dina;
            end else begin
                resp_data_d = mem_q[req_idx];
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= FILL_WORD;
            resp_fault_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            wr_err_q     <= wr_err_d;
        end
    end

    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem_q[wr_idx] <= dina;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: a behavioural memory/response model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_imem_fetch_port;

    localparam logic [31:0] Fill = 32'h003F0000;
    localparam int Depth = 32;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        wea = 1'b0;
    logic [31:0] addra = '0;
    logic [31:0] dina = '0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        flush = 1'b0;
    logic        wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    imem_fetch_port dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_fault (resp_fault),
        .flush      (flush),
        .wr_err     (wr_err)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    // Model: an array of words plus the one response slot the consumer sees.
    logic [31:0] ref_mem [Depth];
    bit          m_valid = 0;
    logic [31:0] m_data = Fill;
    bit          m_fault = 0;
    bit          m_wrerr = 0;

    initial begin
        bit take;
        for (int i = 0; i < Depth; i++) ref_mem[i] = Fill;
        forever begin
            @(posedge clka);
            take = rst_n && req_valid && (!m_valid || resp_ready) && !flush;
            if (!rst_n) begin
                m_valid = 0;
                m_data  = Fill;
                m_fault = 0;
                m_wrerr = 0;
            end else begin
                m_wrerr = wea && (addra >= Depth);
                if (flush) begin
                    m_valid = 0;
                end else if (take) begin
                    m_valid = 1;
                    m_fault = (req_addr >= Depth);
                    if (m_fault) m_data = Fill;
                    else if (wea && addra == req_addr) m_data = dina;
                    else m_data = ref_mem[req_addr];
                end else if (resp_ready) begin
                    m_valid = 0;
                end
                if (wea && addra < Depth) ref_mem[addra] = dina;
            end
        end
    end

    initial begin
        @(posedge clka);
        forever begin
            @(negedge clka);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
            chk("resp_data", resp_data, m_data);
            chk("resp_fault", {31'b0, resp_fault}, {31'b0, m_fault});
            chk("wr_err", {31'b0, wr_err}, {31'b0, m_wrerr});
            chk("req_ready", {31'b0, req_ready},
                {31'b0, rst_n && (!m_valid || resp_ready) && !flush});
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
    endtask

    initial begin
        repeat (3) step();
        chk("rst valid", {31'b0, resp_valid}, 32'd0);
        chk("rst data", resp_data, Fill);
        chk("rst ready", {31'b0, req_ready}, 32'd0);

        // Power-up fetch of 0, 1, 31
        rst_n = 1'b1;
        resp_ready = 1'b1;
        fetch(0);  step(); chk("pu0", resp_data, Fill);
        fetch(1);  step(); chk("pu1", resp_data, Fill);
        fetch(31); step(); chk("pu31", resp_data, Fill);
        chk("pu31 valid", {31'b0, resp_valid}, 32'd1);
        chk("pu31 fault", {31'b0, resp_fault}, 32'd0);
        req_valid = 1'b0; step();

        // Load then fetch
        wea = 1'b1; addra = 1; dina = 32'h781F0000; step();
        addra = 4; dina = 32'h7C1F0000; step();
        wea = 1'b0;
        fetch(1); step(); chk("ld1", resp_data, 32'h781F0000);
        fetch(4); step(); chk("ld4", resp_data, 32'h7C1F0000);
        fetch(2); step(); chk("ld2", resp_data, Fill);
        req_valid = 1'b0; step();

        // Backpressure with a write to the held address
        resp_ready = 1'b0;
        fetch(4); step();
        fetch(5); wea = 1'b1; addra = 4; dina = 32'h0; step();
        chk("bp hold0", resp_data, 32'h7C1F0000);
        chk("bp ready0", {31'b0, req_ready}, 32'd0);
        wea = 1'b0; step();
        chk("bp hold1", resp_data, 32'h7C1F0000);
        step();
        chk("bp hold2", resp_data, 32'h7C1F0000);
        resp_ready = 1'b1; fetch(4); #1;
        chk("bp ready up", {31'b0, req_ready}, 32'd1);
        step();
        chk("bp b2b", resp_data, 32'h0);
        chk("bp b2b valid", {31'b0, resp_valid}, 32'd1);
        req_valid = 1'b0; step();

        // Write/read collision
        wea = 1'b1; addra = 7; dina = 32'hDEADBEEF; fetch(7); step();
        chk("collide", resp_data, 32'hDEADBEEF);
        wea = 1'b0; req_valid = 1'b0; step();

        // Faults
        fetch(32); step();
        chk("fault flag", {31'b0, resp_fault}, 32'd1);
        chk("fault data", resp_data, Fill);
        req_valid = 1'b0;
        wea = 1'b1; addra = 40; dina = 32'h12345678; step();
        chk("wr_err pulse", {31'b0, wr_err}, 32'd1);
        wea = 1'b0; step();
        chk("wr_err clear", {31'b0, wr_err}, 32'd0);
        fetch(8); step();
        chk("no wrap", resp_data, Fill);
        chk("no wrap fault", {31'b0, resp_fault}, 32'd0);
        req_valid = 1'b0; step();

        // Flush while held
        resp_ready = 1'b0; fetch(1); step();
        flush = 1'b1; resp_ready = 1'b1; fetch(2); #1;
        chk("flush ready", {31'b0, req_ready}, 32'd0);
        step();
        chk("flush valid", {31'b0, resp_valid}, 32'd0);
        flush = 1'b0; req_valid = 1'b0; step();
        chk("flush no acc", {31'b0, resp_valid}, 32'd0);

        // Reset mid-stream, with an ignored write
        resp_ready = 1'b0; fetch(4); step();
        rst_n = 1'b0; wea = 1'b1; addra = 1; dina = 32'h5; step();
        chk("mid rst valid", {31'b0, resp_valid}, 32'd0);
        chk("mid rst data", resp_data, Fill);
        chk("mid rst fault", {31'b0, resp_fault}, 32'd0);
        rst_n = 1'b1; wea = 1'b0; resp_ready = 1'b1; fetch(1); step();
        chk("survive", resp_data, 32'h781F0000);

        // Mixed traffic, checked by the model each cycle
        for (int i = 0; i < 60; i++) begin
            wea        = ($urandom_range(0, 3) == 0);
            addra      = $urandom_range(0, 40);
            dina       = $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr   = $urandom_range(0, 36);
            resp_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            rst_n      = ($urandom_range(0, 19) != 0);
            step();
        end
        rst_n = 1'b1; wea = 1'b0; req_valid = 1'b0; flush = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
